ddr3_cmd_decoder: RTL and testbench

Controller-side receiver for the CPU command interface.
- Samples the DDR3-style command bus (CS_N/RAS_N/CAS_N/WE_N, BA, ADDR) every cpu_clk edge and decodes it.
- Tracks open/closed state and open row for each bank.
- Checks tRCD and tRP spacing.
- Forwards legal commands through a single-entry valid/ready output register to the controller's scheduler.
- Flags illegal commands with an error pulse and code.

---
 rtl/ddr3_cmd_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_ddr3_cmd_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_decoder.sv
// DDR3-style command bus receiver: decodes CS/RAS/CAS/WE, tracks per-bank open rows
// and tRCD/tRP spacing, and forwards legal commands through a one-entry valid/ready register.
module ddr3_cmd_decoder #(
  parameter  int ADDR_W    = 14,
  parameter  int NUM_BANKS = 8,
  parameter  int TRCD      = 4,
  parameter  int TRP       = 4,
  localparam int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                 cpu_clk,
  input  logic                 RESET_N,
  input  logic                 CS_N,
  input  logic                 RAS_N,
  input  logic                 CAS_N,
  input  logic                 WE_N,
  input  logic [BA_W-1:0]      BA,
  input  logic [ADDR_W-1:0]    ADDR,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [2:0]           cmd_type,
  output logic [BA_W-1:0]      cmd_bank,
  output logic [ADDR_W-1:0]    cmd_row,
  output logic [9:0]           cmd_col,
  output logic                 cmd_auto_pre,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 err_illegal,
  output logic [2:0]           err_code
);

  localparam int CNT_W = $clog2(((TRCD > TRP) ? TRCD : TRP) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(TRP - 1);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_ACT  = 3'd1;
  localparam logic [2:0] T_RD   = 3'd2;
  localparam logic [2:0] T_WR   = 3'd3;
  localparam logic [2:0] T_PRE  = 3'd4;
  localparam logic [2:0] T_PREA = 3'd5;
  localparam logic [2:0] T_REF  = 3'd6;
  localparam logic [2:0] T_MRS  = 3'd7;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_OVERFLOW = 3'd1;
  localparam logic [2:0] E_CLOSED   = 3'd2;
  localparam logic [2:0] E_OPEN     = 3'd3;
  localparam logic [2:0] E_TRCD     = 3'd4;
  localparam logic [2:0] E_TRP      = 3'd5;
  localparam logic [2:0] E_REF_OPEN = 3'd6;

  logic                             cmd_valid_q, cmd_valid_d;
  logic [2:0]                       cmd_type_q, cmd_type_d;
  logic [BA_W-1:0]                  cmd_bank_q, cmd_bank_d;
  logic [ADDR_W-1:0]                cmd_row_q, cmd_row_d;
  logic [9:0]                       cmd_col_q, cmd_col_d;
  logic                             cmd_auto_pre_q, cmd_auto_pre_d;
  logic [NUM_BANKS-1:0]             bank_open_q, bank_open_d;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] row_q, row_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0]  rcd_q, rcd_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0]  rp_q, rp_d;
  logic                             err_illegal_q, err_illegal_d;
  logic [2:0]                       err_code_q, err_code_d;

  logic [2:0] dec_type_s;
  logic [2:0] err_s;
  logic       legal_s;
  logic       is_col_s;

  // Decode the sampled bus, check legality, and compute next bank and output state.
  always_comb begin
    case ({CS_N, RAS_N, CAS_N, WE_N})
      4'b0011: dec_type_s = T_ACT;
      4'b0101: dec_type_s = T_RD;
      4'b0100: dec_type_s = T_WR;
      4'b0010: dec_type_s = ADDR[10] ? T_PREA : T_PRE;
      4'b0001: dec_type_s = T_REF;
      4'b0000: dec_type_s = T_MRS;
      default: dec_type_s = T_NONE;
    endcase

    is_col_s = (dec_type_s == T_RD) || (dec_type_s == T_WR);

    // Overflow outranks state errors, which outrank timing errors.
    err_s = E_NONE;
    if (dec_type_s == T_NONE) begin
      err_s = E_NONE;
    end else if (cmd_valid_q && !cmd_ready) begin
      err_s = E_OVERFLOW;
    end else begin
      case (dec_type_s)
        T_ACT: begin
          if (bank_open_q[BA])            err_s = E_OPEN;
          else if (rp_q[BA] != CNT_ZERO)  err_s = E_TRP;
          else                            err_s = E_NONE;
        end
        T_RD, T_WR: begin
          if (!bank_open_q[BA])           err_s = E_CLOSED;
          else if (rcd_q[BA] != CNT_ZERO) err_s = E_TRCD;
          else                            err_s = E_NONE;
        end
        T_REF: begin
          if (|bank_open_q)               err_s = E_REF_OPEN;
          else                            err_s = E_NONE;
        end
        default:                          err_s = E_NONE;
      endcase
    end
    legal_s = (dec_type_s != T_NONE) && (err_s == E_NONE);

    bank_open_d = bank_open_q;
    row_d       = row_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      rcd_d[i] = (rcd_q[i] != CNT_ZERO) ? (rcd_q[i] - CNT_W'(1)) : CNT_ZERO;
      rp_d[i]  = (rp_q[i]  != CNT_ZERO) ? (rp_q[i]  - CNT_W'(1)) : CNT_ZERO;
    end

    if (legal_s) begin
      case (dec_type_s)
        T_ACT: begin
          bank_open_d[BA] = 1'b1;
          row_d[BA]       = ADDR;
          rcd_d[BA]       = RCD_LOAD;
        end
        T_PRE: begin
          bank_open_d[BA] = 1'b0;
          rp_d[BA]        = RP_LOAD;
        end
        T_PREA: begin
          for (int i = 0; i < NUM_BANKS; i++) begin
            bank_open_d[i] = 1'b0;
            rp_d[i]        = RP_LOAD;
          end
        end
        T_RD, T_WR: begin
          if (ADDR[10]) begin
            bank_open_d[BA] = 1'b0;
            rp_d[BA]        = RP_LOAD;
          end else begin
            bank_open_d[BA] = bank_open_q[BA];
          end
        end
        default: begin
          bank_open_d = bank_open_q;
        end
      endcase
    end else begin
      bank_open_d = bank_open_q;
    end

    cmd_valid_d    = cmd_valid_q;
    cmd_type_d     = cmd_type_q;
    cmd_bank_d     = cmd_bank_q;
    cmd_row_d      = cmd_row_q;
    cmd_col_d      = cmd_col_q;
    cmd_auto_pre_d = cmd_auto_pre_q;
    if (legal_s) begin
      cmd_valid_d    = 1'b1;
      cmd_type_d     = dec_type_s;
      cmd_bank_d     = BA;
      cmd_col_d      = is_col_s ? ADDR[9:0] : 10'd0;
      cmd_auto_pre_d = is_col_s && ADDR[10];
      if (dec_type_s == T_ACT)  cmd_row_d = ADDR;
      else if (is_col_s)        cmd_row_d = row_q[BA];
      else                      cmd_row_d = {ADDR_W{1'b0}};
    end else if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end

    err_illegal_d = (err_s != E_NONE);
    err_code_d    = (err_s != E_NONE) ? err_s : err_code_q;
  end

  // State and output registers.
  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_valid_q    <= 1'b0;
      cmd_type_q     <= 3'd0;
      cmd_bank_q     <= {BA_W{1'b0}};
      cmd_row_q      <= {ADDR_W{1'b0}};
      cmd_col_q      <= 10'd0;
      cmd_auto_pre_q <= 1'b0;
      bank_open_q    <= {NUM_BANKS{1'b0}};
      row_q          <= {(NUM_BANKS*ADDR_W){1'b0}};
      rcd_q          <= {(NUM_BANKS*CNT_W){1'b0}};
      rp_q           <= {(NUM_BANKS*CNT_W){1'b0}};
      err_illegal_q  <= 1'b0;
      err_code_q     <= 3'd0;
    end else begin
      cmd_valid_q    <= cmd_valid_d;
      cmd_type_q     <= cmd_type_d;
      cmd_bank_q     <= cmd_bank_d;
      cmd_row_q      <= cmd_row_d;
      cmd_col_q      <= cmd_col_d;
      cmd_auto_pre_q <= cmd_auto_pre_d;
      bank_open_q    <= bank_open_d;
      row_q          <= row_d;
      rcd_q          <= rcd_d;
      rp_q           <= rp_d;
      err_illegal_q  <= err_illegal_d;
      err_code_q     <= err_code_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_type     = cmd_type_q;
  assign cmd_bank     = cmd_bank_q;
  assign cmd_row      = cmd_row_q;
  assign cmd_col      = cmd_col_q;
  assign cmd_auto_pre = cmd_auto_pre_q;
  assign bank_open    = bank_open_q;
  assign err_illegal  = err_illegal_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Directed bench for ddr3_cmd_decoder: a cycle-stamp reference model checked every cycle,
// plus hand-computed expectations along the test plan.
module tb_ddr3_cmd_decoder;

  localparam int TRCD = 4;
  localparam int TRP  = 4;

  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ZQ  = 4'b0110;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        CS_N, RAS_N, CAS_N, WE_N;
  logic [2:0]  BA;
  logic [13:0] ADDR;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bank;
  logic [13:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_auto_pre;
  logic [7:0]  bank_open;
  logic        err_illegal;
  logic [2:0]  err_code;

  ddr3_cmd_decoder #(.ADDR_W(14), .NUM_BANKS(8), .TRCD(TRCD), .TRP(TRP)) dut (
    .cpu_clk(clk), .RESET_N(RESET_N),
    .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
    .BA(BA), .ADDR(ADDR),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_auto_pre(cmd_auto_pre), .bank_open(bank_open),
    .err_illegal(err_illegal), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: bank state plus the edge index of the last ACT / precharge per bank.
  int          t;
  logic [7:0]  m_open;
  logic [13:0] m_row [8];
  int          m_act_t [8];
  int          m_pre_t [8];
  logic        exp_valid, exp_ap, exp_pulse;
  logic [2:0]  exp_type, exp_bank, exp_code;
  logic [13:0] exp_row;
  logic [9:0]  exp_col;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_open = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_row[i] = 14'd0; m_act_t[i] = -1000; m_pre_t[i] = -1000;
    end
    exp_valid = 1'b0; exp_ap = 1'b0; exp_pulse = 1'b0;
    exp_type = 3'd0; exp_bank = 3'd0; exp_code = 3'd0;
    exp_row = 14'd0; exp_col = 10'd0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [2:0] ba, input logic [13:0] addr,
                            input logic rdy);
    int typ, e;
    bit col;
    case (c)
      C_ACT:   typ = 1;
      C_RD:    typ = 2;
      C_WR:    typ = 3;
      C_PRE:   typ = addr[10] ? 5 : 4;
      C_REF:   typ = 6;
      C_MRS:   typ = 7;
      default: typ = 0;
    endcase
    col = (typ == 2) || (typ == 3);
    e = 0;
    if (typ != 0) begin
      if (exp_valid && !rdy)   e = 1;
      else if (typ == 1)       e = m_open[ba] ? 3 : ((t - m_pre_t[ba] < TRP) ? 5 : 0);
      else if (col)            e = !m_open[ba] ? 2 : ((t - m_act_t[ba] < TRCD) ? 4 : 0);
      else if (typ == 6)       e = (m_open != 8'h00) ? 6 : 0;
    end
    exp_pulse = (e != 0);
    if (e != 0) exp_code = 3'(e);
    if (typ != 0 && e == 0) begin
      exp_valid = 1'b1;
      exp_type  = 3'(typ);
      exp_bank  = ba;
      exp_col   = col ? addr[9:0] : 10'd0;
      exp_ap    = col && addr[10];
      exp_row   = (typ == 1) ? addr : (col ? m_row[ba] : 14'd0);
      if (typ == 1) begin
        m_open[ba] = 1'b1; m_row[ba] = addr; m_act_t[ba] = t;
      end else if (typ == 4 || (col && addr[10])) begin
        m_open[ba] = 1'b0; m_pre_t[ba] = t;
      end else if (typ == 5) begin
        m_open = 8'h00;
        for (int i = 0; i < 8; i++) m_pre_t[i] = t;
      end
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    t++;
  endtask

  // Drive one bus cycle, advance the model at the sampling edge, return on the next falling edge.
  task automatic cyc(input logic [3:0] c, input logic [2:0] ba, input logic [13:0] addr,
                     input logic rdy);
    {CS_N, RAS_N, CAS_N, WE_N} = c;
    BA = ba; ADDR = addr; cmd_ready = rdy;
    @(posedge clk);
    model_step(c, ba, addr, rdy);
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(C_NOP, 3'd0, 14'd0, 1'b1);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cmd_valid", cmd_valid, exp_valid);
      if (exp_valid) begin
        chk("cmd_type", cmd_type, exp_type);
        chk("cmd_bank", cmd_bank, exp_bank);
        chk("cmd_row", cmd_row, exp_row);
        chk("cmd_col", cmd_col, exp_col);
        chk("cmd_auto_pre", cmd_auto_pre, exp_ap);
      end
      chk("bank_open", bank_open, m_open);
      chk("err_illegal", err_illegal, exp_pulse);
      chk("err_code", err_code, exp_code);
    end
  end

  initial begin
    t = 0;
    reset_model();
    RESET_N = 1'b0;
    {CS_N, RAS_N, CAS_N, WE_N} = C_DES;
    BA = 3'd0; ADDR = 14'd0; cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_type", cmd_type, 3'd0);
    chk("rst_row", cmd_row, 14'd0);
    chk("rst_bank_open", bank_open, 8'h00);
    chk("rst_err", {err_illegal, err_code}, 4'h0);
    RESET_N = 1'b1;
    check_en = 1'b1;

    // ACT then RD after tRCD
    cyc(C_ACT, 3'd0, 14'd5, 1'b1);
    chk("act0_type", cmd_type, 3'd1);
    chk("act0_open", bank_open, 8'h01);
    nops(3);
    cyc(C_RD, 3'd0, 14'd5, 1'b1);
    chk("rd0_row_col", {cmd_valid, cmd_type, cmd_row, cmd_col, cmd_auto_pre},
        {1'b1, 3'd2, 14'd5, 10'd5, 1'b0});

    // tRCD violation, then retry at +4
    cyc(C_ACT, 3'd2, 14'd9, 1'b1);
    cyc(C_RD, 3'd2, 14'd0, 1'b1);
    chk("trcd_err", {err_illegal, err_code, cmd_valid}, {1'b1, 3'd4, 1'b0});
    nops(2);
    cyc(C_RD, 3'd2, 14'd3, 1'b1);
    chk("trcd_retry", {cmd_valid, cmd_type, cmd_row, err_illegal, err_code},
        {1'b1, 3'd2, 14'd9, 1'b0, 3'd4});

    // Auto-precharge, tRP violation, then legal ACT
    cyc(C_ACT, 3'd1, 14'd7, 1'b1);
    nops(3);
    cyc(C_RD, 3'd1, 14'h403, 1'b1);
    chk("ap_rd", {cmd_auto_pre, cmd_col, bank_open}, {1'b1, 10'd3, 8'h05});
    nops(1);
    cyc(C_ACT, 3'd1, 14'd7, 1'b1);
    chk("trp_err", {err_illegal, err_code}, {1'b1, 3'd5});
    nops(1);
    cyc(C_ACT, 3'd1, 14'd7, 1'b1);
    chk("trp_ok", {cmd_valid, cmd_type, bank_open}, {1'b1, 3'd1, 8'h07});

    // Precharge-all, then backpressure / overflow
    cyc(C_PRE, 3'd0, 14'h400, 1'b1);
    chk("prea", {cmd_type, bank_open}, {3'd5, 8'h00});
    nops(3);
    cyc(C_ACT, 3'd0, 14'd1, 1'b0);
    cyc(C_ZQ, 3'd0, 14'd0, 1'b0);
    cyc(C_DES, 3'd0, 14'd0, 1'b0);
    chk("zq_des_noop", {cmd_valid, err_illegal, err_code}, {1'b1, 1'b0, 3'd5});
    cyc(C_ACT, 3'd3, 14'd2, 1'b0);
    chk("overflow", {err_illegal, err_code, bank_open, cmd_type, cmd_bank},
        {1'b1, 3'd1, 8'h01, 3'd1, 3'd0});
    cyc(C_ACT, 3'd3, 14'd2, 1'b1);
    chk("ready_load", {cmd_valid, cmd_bank, cmd_row, err_illegal, err_code},
        {1'b1, 3'd3, 14'd2, 1'b0, 3'd1});
    nops(3);
    cyc(C_WR, 3'd3, 14'h00A, 1'b1);
    chk("wr", {cmd_type, cmd_row, cmd_col}, {3'd3, 14'd2, 10'hA});

    // PREA with banks open, REF rules, MRS, PRE to closed bank
    cyc(C_ACT, 3'd4, 14'd4, 1'b1);
    chk("open_0_3_4", bank_open, 8'h19);
    cyc(C_PRE, 3'd2, 14'h400, 1'b1);
    chk("prea2", {cmd_type, bank_open}, {3'd5, 8'h00});
    nops(1);
    cyc(C_REF, 3'd0, 14'd0, 1'b1);
    chk("ref_ok", {cmd_valid, cmd_type, err_illegal}, {1'b1, 3'd6, 1'b0});
    nops(1);
    cyc(C_ACT, 3'd0, 14'd1, 1'b1);
    cyc(C_REF, 3'd0, 14'd0, 1'b1);
    chk("ref_open", {err_illegal, err_code}, {1'b1, 3'd6});
    cyc(C_MRS, 3'd1, 14'h123, 1'b1);
    chk("mrs", {cmd_valid, cmd_type, cmd_col}, {1'b1, 3'd7, 10'd0});
    cyc(C_PRE, 3'd5, 14'd0, 1'b1);
    chk("pre_closed", {cmd_type, cmd_bank, bank_open}, {3'd4, 3'd5, 8'h01});
    cyc(C_ACT, 3'd0, 14'd2, 1'b1);
    chk("act_open", {err_illegal, err_code}, {1'b1, 3'd3});
    cyc(C_RD, 3'd6, 14'd0, 1'b1);
    chk("rd_closed", {err_illegal, err_code}, {1'b1, 3'd2});

    // Reset while a command is pending
    cyc(C_ACT, 3'd6, 14'd3, 1'b0);
    chk("pre_reset", {cmd_valid, bank_open}, {1'b1, 8'h41});
    check_en = 1'b0;
    {CS_N, RAS_N, CAS_N, WE_N} = C_NOP;
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst", {cmd_valid, bank_open, err_code, err_illegal}, {1'b0, 8'h00, 3'd0, 1'b0});
    reset_model();
    @(negedge clk);
    RESET_N = 1'b1;
    check_en = 1'b1;
    cyc(C_ACT, 3'd2, 14'd1, 1'b1);
    chk("post_rst_act", {cmd_valid, cmd_type, bank_open}, {1'b1, 3'd1, 8'h04});
    nops(2);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
